// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
//
// Memory stage of the pipeline. It sits after the EX/MEM register and drives
// the MEM/WB register. Loads and stores go to the data-memory port through a
// req/ack handshake. Store data is lane-replicated and byte enables are
// generated. Load data is extracted from its lane and sign- or zero-extended.
// Upstream stages are stalled while a memory transaction is outstanding.
//
// Optional feature macro: LSU_ACK_TIMEOUT_EN
//   If defined, a BUSY-cycle counter aborts a transaction that has not been
//   acknowledged after TIMEOUT_CYCLES cycles. The abort is reported on
//   o_bus_err. If undefined, BUSY waits indefinitely and o_bus_err stays 0.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_pc .. i_ctrl_funct3   instruction fields coming from EX/MEM
//   o_stall                 holds EX/MEM and earlier stages (combinational)
//   o_dmem_* / i_dmem_*     data-memory request/response port
//   o_wb_*                  MEM/WB instruction fields
//   o_misalign, o_bus_err   exception flags, valid together with o_wb_valid
// -----------------------------------------------------------------------------
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_store_data,
  input  logic [4:0]  i_rd,
  input  logic        i_ctrl_valid,
  input  logic        i_ctrl_bubble,
  input  logic        i_ctrl_mem_read,
  input  logic        i_ctrl_mem_write,
  input  logic        i_ctrl_wb_en,
  input  logic [2:0]  i_ctrl_funct3,
  output logic        o_stall,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_be,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_wb_valid,
  output logic        o_wb_en,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  output logic [31:0] o_wb_pc,
  output logic        o_misalign,
  output logic        o_bus_err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Selects the addressed lane of a read word and extends it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] rdata,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{lane, 3'b000} +: 8];
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b100:  load_extend = {24'h000000, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b101:  load_extend = {16'h0000, h};
      default: load_extend = rdata;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;
  logic [4:0]  rd_q, rd_d;
  logic        wben_q, wben_d;
  logic [31:0] pc_q, pc_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_en_q, wb_en_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [31:0] wb_pc_q, wb_pc_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;

  logic live_s, mem_op_s, is_byte_s, is_half_s, misalign_s, start_s;
  logic stall_s, timeout_s;

  // Decode of the instruction presented by EX/MEM; a read wins over a write.
  assign live_s    = i_ctrl_valid & ~i_ctrl_bubble;
  assign mem_op_s  = live_s & (i_ctrl_mem_read | i_ctrl_mem_write);
  assign is_byte_s = i_ctrl_mem_read ? ((i_ctrl_funct3 == 3'b000) | (i_ctrl_funct3 == 3'b100))
                                     : (i_ctrl_funct3 == 3'b000);
  assign is_half_s = i_ctrl_mem_read ? ((i_ctrl_funct3 == 3'b001) | (i_ctrl_funct3 == 3'b101))
                                     : (i_ctrl_funct3 == 3'b001);
  assign misalign_s = mem_op_s &
                      ((is_half_s & i_alu_result[0]) |
                       (~is_byte_s & ~is_half_s & (i_alu_result[1:0] != 2'b00)));
  assign start_s   = mem_op_s & ~misalign_s;

`ifdef LSU_ACK_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Abort condition: last allowed BUSY cycle passed without an ack.
  assign timeout_s = (state_q == BUSY) & ~i_dmem_ack &
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counter restarts on each new transaction and advances per unacked BUSY cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (!i_dmem_ack) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Timeout counter register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout_s;
  assign unused_timeout_s = |TIMEOUT_CYCLES;
  assign timeout_s        = 1'b0;
`endif

  // Next-state, request and writeback logic; requests hold their value by default.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    f3_d       = f3_q;
    lane_d     = lane_q;
    rd_d       = rd_q;
    wben_d     = wben_q;
    pc_d       = pc_q;
    wb_valid_d = 1'b0;
    wb_en_d    = 1'b0;
    wb_rd_d    = 5'd0;
    wb_data_d  = 32'h0000_0000;
    wb_pc_d    = wb_pc_q;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;
    stall_s    = 1'b0;
    case (state_q)
      IDLE: begin
        wb_pc_d = i_pc;
        if (start_s) begin
          stall_s = 1'b1;
          state_d = BUSY;
          req_d   = 1'b1;
          we_d    = ~i_ctrl_mem_read;
          addr_d  = {i_alu_result[31:2], 2'b00};
          f3_d    = i_ctrl_funct3;
          lane_d  = i_alu_result[1:0];
          rd_d    = i_rd;
          wben_d  = i_ctrl_wb_en;
          pc_d    = i_pc;
          if (i_ctrl_mem_read) begin
            be_d    = 4'b1111;
            wdata_d = 32'h0000_0000;
          end else if (is_byte_s) begin
            be_d    = 4'b0001 << i_alu_result[1:0];
            wdata_d = {4{i_store_data[7:0]}};
          end else if (is_half_s) begin
            be_d    = i_alu_result[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{i_store_data[15:0]}};
          end else begin
            be_d    = 4'b1111;
            wdata_d = i_store_data;
          end
        end else if (misalign_s) begin
          // Misaligned access: report without touching the memory port.
          wb_valid_d = 1'b1;
          misalign_d = 1'b1;
          wb_rd_d    = i_rd;
        end else if (live_s) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = i_rd;
          wb_data_d  = i_alu_result;
          wb_en_d    = i_ctrl_wb_en & (i_rd != 5'd0);
        end else begin
          wb_valid_d = 1'b0;
        end
      end
      BUSY: begin
        if (i_dmem_ack) begin
          state_d    = IDLE;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_pc_d    = pc_q;
          if (!we_q) begin
            wb_en_d   = wben_q & (rd_q != 5'd0);
            wb_data_d = load_extend(i_dmem_rdata, lane_q, f3_q);
          end else begin
            wb_en_d   = 1'b0;
          end
        end else if (timeout_s) begin
          state_d    = IDLE;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          bus_err_d  = 1'b1;
          wb_rd_d    = rd_q;
          wb_pc_d    = pc_q;
        end else begin
          stall_s = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State, request and MEM/WB registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0000_0000;
      wdata_q    <= 32'h0000_0000;
      be_q       <= 4'b0000;
      f3_q       <= 3'b000;
      lane_q     <= 2'b00;
      rd_q       <= 5'd0;
      wben_q     <= 1'b0;
      pc_q       <= 32'h0000_0000;
      wb_valid_q <= 1'b0;
      wb_en_q    <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 32'h0000_0000;
      wb_pc_q    <= 32'h0000_0000;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      f3_q       <= f3_d;
      lane_q     <= lane_d;
      rd_q       <= rd_d;
      wben_q     <= wben_d;
      pc_q       <= pc_d;
      wb_valid_q <= wb_valid_d;
      wb_en_q    <= wb_en_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_pc_q    <= wb_pc_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign o_stall      = stall_s;
  assign o_dmem_req   = req_q;
  assign o_dmem_we    = we_q;
  assign o_dmem_addr  = addr_q;
  assign o_dmem_wdata = wdata_q;
  assign o_dmem_be    = be_q;
  assign o_wb_valid   = wb_valid_q;
  assign o_wb_en      = wb_en_q;
  assign o_wb_rd      = wb_rd_q;
  assign o_wb_data    = wb_data_q;
  assign o_wb_pc      = wb_pc_q;
  assign o_misalign   = misalign_q;
  assign o_bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed testbench for mem_stage_lsu. Inputs change 1 time unit after the
// rising edge; registered outputs and the combinational stall are sampled
// after that settle delay.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, alu, sd, rdata;
  logic [4:0]  rd;
  logic        valid, bubble, mrd, mwr, wben, ack;
  logic [2:0]  f3;
  logic        stall, req, we, wb_valid, wb_en, misalign, bus_err;
  logic [31:0] addr, wdata, wb_data, wb_pc;
  logic [3:0]  be;
  logic [4:0]  wb_rd;

  int n_checks = 0;
  int n_fails  = 0;
  int stall_cnt;

  always #5 clk = ~clk;

  mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_pc(pc), .i_alu_result(alu),
    .i_store_data(sd), .i_rd(rd), .i_ctrl_valid(valid),
    .i_ctrl_bubble(bubble), .i_ctrl_mem_read(mrd), .i_ctrl_mem_write(mwr),
    .i_ctrl_wb_en(wben), .i_ctrl_funct3(f3), .o_stall(stall),
    .o_dmem_req(req), .o_dmem_we(we), .o_dmem_addr(addr),
    .o_dmem_wdata(wdata), .o_dmem_be(be), .i_dmem_ack(ack),
    .i_dmem_rdata(rdata), .o_wb_valid(wb_valid), .o_wb_en(wb_en),
    .o_wb_rd(wb_rd), .o_wb_data(wb_data), .o_wb_pc(wb_pc),
    .o_misalign(misalign), .o_bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic b, input logic r, input logic w,
                       input logic we_in, input logic [2:0] fn, input logic [31:0] a,
                       input logic [31:0] s, input logic [4:0] d, input logic [31:0] p);
    valid = v; bubble = b; mrd = r; mwr = w; wben = we_in;
    f3 = fn; alu = a; sd = s; rd = d; pc = p;
    #1;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0);
  endtask

  // Check the result of a completed writeback.
  task automatic chk_wb(input string tag, input logic v, input logic en,
                        input logic [31:0] data, input logic [4:0] d);
    chk({tag, "_valid"}, {31'h0, wb_valid}, {31'h0, v});
    chk({tag, "_en"},    {31'h0, wb_en},    {31'h0, en});
    chk({tag, "_data"},  wb_data, data);
    chk({tag, "_rd"},    {27'h0, wb_rd},    {27'h0, d});
  endtask

  initial begin
    rst = 1'b1; ack = 1'b0; rdata = 32'h0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 32'h55, 32'h0, 5'd7, 32'h1234);
    // ---- reset state ----
    tick(); tick();
    chk("rst_req", {31'h0, req}, 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_be", {28'h0, be}, 32'h0);
    chk("rst_wb_pc", wb_pc, 32'h0);
    chk("rst_flags", {29'h0, misalign, bus_err, we}, 32'h0);
    chk_wb("rst", 1'b0, 1'b0, 32'h0, 5'd0);
    rst = 1'b0;
    idle_in();
    tick();

    // ---- LW 0x1004, ack with the request ----
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 32'h1004, 32'h0, 5'd5, 32'h40);
    chk("lw_stall_n", {31'h0, stall}, 32'h1);
    tick();
    chk("lw_req", {31'h0, req}, 32'h1);
    chk("lw_addr", addr, 32'h1004);
    chk("lw_be", {28'h0, be}, 32'hF);
    chk("lw_we", {31'h0, we}, 32'h0);
    chk("lw_busy_valid", {31'h0, wb_valid}, 32'h0);
    ack = 1'b1; rdata = 32'hDEADBEEF; #1;
    chk("lw_stall_ack", {31'h0, stall}, 32'h0);
    tick();
    ack = 1'b0; idle_in();
    chk_wb("lw", 1'b1, 1'b1, 32'hDEADBEEF, 5'd5);
    chk("lw_req_drop", {31'h0, req}, 32'h0);
    chk("lw_pc", wb_pc, 32'h40);

    // ---- LB / LBU at 0x2003 ----
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 32'h2003, 32'h0, 5'd6, 32'h44);
    tick();
    chk("lb_addr", addr, 32'h2000);
    ack = 1'b1; rdata = 32'h80112233;
    tick();
    ack = 1'b0;
    chk_wb("lb", 1'b1, 1'b1, 32'hFFFFFF80, 5'd6);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b100, 32'h2003, 32'h0, 5'd6, 32'h48);
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0; idle_in();
    chk_wb("lbu", 1'b1, 1'b1, 32'h00000080, 5'd6);

    // ---- SH 0x3002 with three wait cycles ----
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 32'h3002, 32'h0000ABCD, 5'd0, 32'h4C);
    stall_cnt = 0;
    if (stall) stall_cnt++;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (stall) stall_cnt++;
      chk($sformatf("sh_req_%0d", i), {31'h0, req}, 32'h1);
      chk($sformatf("sh_be_%0d", i), {28'h0, be}, 32'hC);
      chk($sformatf("sh_wdata_%0d", i), wdata, 32'hABCDABCD);
      chk($sformatf("sh_we_%0d", i), {31'h0, we}, 32'h1);
      tick();
    end
    chk("sh_addr", addr, 32'h3000);
    ack = 1'b1; #1;
    if (stall) stall_cnt++;
    chk("sh_stall_cycles", stall_cnt, 32'd4);
    tick();
    ack = 1'b0; idle_in();
    chk_wb("sh", 1'b1, 1'b0, 32'h0, 5'd0);

    // ---- misaligned LW 0x4001 ----
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 32'h4001, 32'h0, 5'd9, 32'h50);
    chk("mis_stall", {31'h0, stall}, 32'h0);
    tick();
    idle_in();
    chk("mis_req", {31'h0, req}, 32'h0);
    chk("mis_flag", {31'h0, misalign}, 32'h1);
    chk_wb("mis", 1'b1, 1'b0, 32'h0, 5'd9);

    // ---- ADD, bubble, SW ----
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 32'h7, 32'h0, 5'd3, 32'h60);
    chk("add_stall", {31'h0, stall}, 32'h0);
    tick();
    chk_wb("add", 1'b1, 1'b1, 32'h7, 5'd3);
    chk("add_pc", wb_pc, 32'h60);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h99, 32'h0, 5'd4, 32'h64);
    tick();
    chk_wb("bub", 1'b0, 1'b0, 32'h0, 5'd0);
    chk("bub_pc", wb_pc, 32'h64);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 32'h5008, 32'h12345678, 5'd0, 32'h68);
    chk("sw_stall", {31'h0, stall}, 32'h1);
    tick();
    chk("sw_req", {31'h0, req}, 32'h1);
    chk("sw_addr", addr, 32'h5008);
    chk("sw_wdata", wdata, 32'h12345678);
    chk("sw_be", {28'h0, be}, 32'hF);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk_wb("sw", 1'b1, 1'b0, 32'h0, 5'd0);

    // ---- writeback to x0 is suppressed ----
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 32'h11, 32'h0, 5'd0, 32'h6C);
    tick();
    chk_wb("x0", 1'b1, 1'b0, 32'h11, 5'd0);

    // ---- reset while BUSY, late ack ignored ----
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 32'h6000, 32'h0, 5'd8, 32'h70);
    tick();
    tick();
    chk("rb_req_busy", {31'h0, req}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0; idle_in();
    chk("rb_req", {31'h0, req}, 32'h0);
    chk("rb_addr", addr, 32'h0);
    chk_wb("rb", 1'b0, 1'b0, 32'h0, 5'd0);
    ack = 1'b1; rdata = 32'hCAFEF00D; #1;
    chk("rb_late_stall", {31'h0, stall}, 32'h0);
    tick();
    ack = 1'b0;
    chk("rb_late_req", {31'h0, req}, 32'h0);
    chk_wb("rb_late", 1'b0, 1'b0, 32'h0, 5'd0);
    chk("rb_bus_err", {31'h0, bus_err}, 32'h0);

`ifdef LSU_ACK_TIMEOUT_EN
    // ---- timeout after four unacknowledged BUSY cycles ----
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 32'h7000, 32'h0, 5'd2, 32'h80);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("to_stall_%0d", i), {31'h0, stall}, 32'h1);
      tick();
    end
    chk("to_stall_last", {31'h0, stall}, 32'h0);
    chk("to_req_last", {31'h0, req}, 32'h1);
    tick();
    idle_in();
    chk("to_req", {31'h0, req}, 32'h0);
    chk("to_bus_err", {31'h0, bus_err}, 32'h1);
    chk_wb("to", 1'b1, 1'b0, 32'h0, 5'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
